tone_divider_gen: RTL and testbench

TONE_DIVIDER_GEN -- requirements
Module: tone_divider_gen

---
 rtl/tone_divider_gen.sv | 126 ++++++++++++
 tb/tb_tone_divider_gen.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/tone_divider_gen.sv
// rtl/tone_divider_gen.sv - note/octave square-wave tone generator with glitch-free retune
// Half-period is clk_div_num + 1 cycles; a new divider only lands on a half-period boundary.
module tone_divider_gen #(
  parameter int DIV_WIDTH = 32,
  parameter int OCT_BITS  = 2,
  parameter logic [DIV_WIDTH-1:0] DO_DIV  = 32'hBAA2,
  parameter logic [DIV_WIDTH-1:0] RE_DIV  = 32'hA646,
  parameter logic [DIV_WIDTH-1:0] MI_DIV  = 32'h9422,
  parameter logic [DIV_WIDTH-1:0] FA_DIV  = 32'h8BE8,
  parameter logic [DIV_WIDTH-1:0] SO_DIV  = 32'h7CB8,
  parameter logic [DIV_WIDTH-1:0] LA_DIV  = 32'h6EFA,
  parameter logic [DIV_WIDTH-1:0] SI_DIV  = 32'h62F2,
  parameter logic [DIV_WIDTH-1:0] DOH_DIV = 32'h5D5C
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           note_sel,
  input  logic [OCT_BITS-1:0]  octave,
  output logic                 tone_out,
  output logic [DIV_WIDTH-1:0] clk_div_num,
  output logic                 tone_edge,
  output logic                 note_change
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t               r_state, w_state_nxt;
  logic [2:0]           r_note;
  logic [OCT_BITS-1:0]  r_oct;
  logic [DIV_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [DIV_WIDTH-1:0] r_div, w_div_nxt;
  logic                 r_tone, w_tone_nxt;
  logic                 r_edge, w_edge_nxt;
  logic                 r_chg, w_chg_nxt;
  logic [DIV_WIDTH-1:0] w_base;
  logic [DIV_WIDTH-1:0] w_shift;
  logic [DIV_WIDTH-1:0] w_t;

  assign tone_out    = r_tone;
  assign clk_div_num = r_div;
  assign tone_edge   = r_edge;
  assign note_change = r_chg;

  always_comb begin
    w_base = DO_DIV;
    case (r_note)
      3'd0: w_base = DO_DIV;
      3'd1: w_base = RE_DIV;
      3'd2: w_base = MI_DIV;
      3'd3: w_base = FA_DIV;
      3'd4: w_base = SO_DIV;
      3'd5: w_base = LA_DIV;
      3'd6: w_base = SI_DIV;
      3'd7: w_base = DOH_DIV;
      default: w_base = DO_DIV;
    endcase
  end

  // A zero divider would stall the counter reload; clamp to the fastest tone instead.
  assign w_shift = w_base >> r_oct;
  assign w_t     = (w_shift == '0) ? DIV_WIDTH'(1) : w_shift;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_div_nxt   = r_div;
    w_tone_nxt  = r_tone;
    w_edge_nxt  = 1'b0;
    w_chg_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_tone_nxt = 1'b0;
        w_cnt_nxt  = '0;
        if (enable) begin
          w_state_nxt = ST_RUN;
          w_div_nxt   = w_t;
          w_cnt_nxt   = w_t;
          w_chg_nxt   = 1'b1;
        end
      end
      ST_RUN: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - DIV_WIDTH'(1);
        end else if (!enable && r_tone) begin
          // Only leave from the end of a high phase so the last pulse is never cut short.
          w_state_nxt = ST_IDLE;
          w_tone_nxt  = 1'b0;
          w_edge_nxt  = 1'b1;
        end else begin
          w_tone_nxt = ~r_tone;
          w_edge_nxt = 1'b1;
          w_cnt_nxt  = w_t;
          if (w_t != r_div) begin
            w_div_nxt = w_t;
            w_chg_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_note  <= '0;
      r_oct   <= '0;
      r_cnt   <= '0;
      r_div   <= DO_DIV;
      r_tone  <= 1'b0;
      r_edge  <= 1'b0;
      r_chg   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_note  <= note_sel;
      r_oct   <= octave;
      r_cnt   <= w_cnt_nxt;
      r_div   <= w_div_nxt;
      r_tone  <= w_tone_nxt;
      r_edge  <= w_edge_nxt;
      r_chg   <= w_chg_nxt;
    end
  end

endmodule

// File: tb/tb_tone_divider_gen.sv
// tb/tb_tone_divider_gen.sv - directed bench for tone_divider_gen with a shortened divider table
// Table: DO=40 RE=36 MI=32 FA=28 SO=24 LA=20 SI=16 DOH=5; half-period = divider + 1.
module tb_tone_divider_gen;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        enable;
  logic [2:0]  note_sel;
  logic [1:0]  octave;
  logic        tone_out;
  logic [31:0] clk_div_num;
  logic        tone_edge;
  logic        note_change;

  int total = 0;
  int bad = 0;
  int nc_cnt = 0;
  int te_cnt = 0;

  tone_divider_gen #(
    .DIV_WIDTH(32), .OCT_BITS(2),
    .DO_DIV(32'd40), .RE_DIV(32'd36), .MI_DIV(32'd32), .FA_DIV(32'd28),
    .SO_DIV(32'd24), .LA_DIV(32'd20), .SI_DIV(32'd16), .DOH_DIV(32'd5)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .enable(enable), .note_sel(note_sel),
    .octave(octave), .tone_out(tone_out), .clk_div_num(clk_div_num),
    .tone_edge(tone_edge), .note_change(note_change)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) begin
    #2;
    if (note_change) nc_cnt++;
    if (tone_edge) te_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  // Counts negedges until tone_edge is seen; a missing edge returns 201.
  task automatic wait_edge(output int cnt);
    cnt = 0;
    while (cnt <= 200) begin
      @(negedge CLOCK_50);
      cnt++;
      if (tone_edge) break;
    end
  endtask

  int c;
  int base_nc;
  int base_te;

  initial begin
    reset = 1'b1; enable = 1'b0; note_sel = 3'd0; octave = 2'd0;
    step(3);
    check_val("rst_tone", {31'd0, tone_out}, 32'd0);
    check_val("rst_edge", {31'd0, tone_edge}, 32'd0);
    check_val("rst_chg", {31'd0, note_change}, 32'd0);
    check_val("rst_div", clk_div_num, 32'd40);

    // High Do, octave 0: divider 5, half-period 6
    reset = 1'b0; note_sel = 3'd7; octave = 2'd0;
    step(2);
    check_val("idle_tone", {31'd0, tone_out}, 32'd0);
    base_nc = nc_cnt;
    enable = 1'b1;
    step(1);
    check_val("start_chg", {31'd0, note_change}, 32'd1);
    check_val("start_div", clk_div_num, 32'd5);
    wait_edge(c); check_val("doh_half1", c, 32'd6);
    check_val("doh_tone1", {31'd0, tone_out}, 32'd1);
    wait_edge(c); check_val("doh_half2", c, 32'd6);
    check_val("doh_tone2", {31'd0, tone_out}, 32'd0);
    check_val("doh_chg_cnt", nc_cnt - base_nc, 32'd1);

    // Octave 3 shifts 5 to 0, clamped to 1: half-period 2
    octave = 2'd3;
    wait_edge(c); check_val("oct3_cur", c, 32'd6);
    check_val("oct3_div", clk_div_num, 32'd1);
    wait_edge(c); check_val("oct3_half", c, 32'd2);
    wait_edge(c); check_val("oct3_half2", c, 32'd2);

    // Do, octave 2: 40 >> 2 = 10
    note_sel = 3'd0; octave = 2'd2;
    wait_edge(c); check_val("do_o2_cur", c, 32'd2);
    check_val("do_o2_div", clk_div_num, 32'd10);
    wait_edge(c); check_val("do_o2_half", c, 32'd11);

    // Mid-half-period change Do -> So
    octave = 2'd0;
    wait_edge(c); check_val("do_cur", c, 32'd11);
    check_val("do_div", clk_div_num, 32'd40);
    base_nc = nc_cnt;
    step(10);
    note_sel = 3'd4;
    wait_edge(c); check_val("mid_half", c + 10, 32'd41);
    check_val("mid_div", clk_div_num, 32'd24);
    wait_edge(c); check_val("so_half", c, 32'd25);
    check_val("mid_chg_cnt", nc_cnt - base_nc, 32'd1);

    // Several changes in one half-period: only the last one (Mi) lands
    base_nc = nc_cnt;
    step(3); note_sel = 3'd0;
    step(3); note_sel = 3'd1;
    step(3); note_sel = 3'd2;
    wait_edge(c); check_val("multi_half", c + 9, 32'd25);
    check_val("multi_div", clk_div_num, 32'd32);
    wait_edge(c); check_val("mi_half", c, 32'd33);
    check_val("multi_chg_cnt", nc_cnt - base_nc, 32'd1);

    // Drop enable during a low phase: low and high phases complete, then idle
    if (tone_out) wait_edge(c);
    enable = 1'b0;
    wait_edge(c); check_val("off_low", c, 32'd33);
    check_val("off_tone_hi", {31'd0, tone_out}, 32'd1);
    wait_edge(c); check_val("off_high", c, 32'd33);
    check_val("off_tone_lo", {31'd0, tone_out}, 32'd0);
    base_te = te_cnt;
    step(20);
    check_val("idle_edges", te_cnt - base_te, 32'd0);
    check_val("idle_tone2", {31'd0, tone_out}, 32'd0);

    // Re-enable, then drop and restore enable just before the boundary
    enable = 1'b1;
    step(1);
    check_val("re_chg", {31'd0, note_change}, 32'd1);
    wait_edge(c); check_val("re_half", c, 32'd33);
    check_val("re_tone", {31'd0, tone_out}, 32'd1);
    enable = 1'b0;
    step(32);
    enable = 1'b1;
    wait_edge(c); check_val("keep_rest", c, 32'd1);
    wait_edge(c); check_val("keep_half", c, 32'd33);
    check_val("keep_tone", {31'd0, tone_out}, 32'd1);

    // Reset mid high phase: immediate drop, no edge; registered note restarts at Do
    step(10);
    reset = 1'b1;
    step(1);
    check_val("mrst_tone", {31'd0, tone_out}, 32'd0);
    check_val("mrst_edge", {31'd0, tone_edge}, 32'd0);
    check_val("mrst_chg", {31'd0, note_change}, 32'd0);
    check_val("mrst_div", clk_div_num, 32'd40);
    reset = 1'b0;
    step(1);
    check_val("post_chg", {31'd0, note_change}, 32'd1);
    check_val("post_div", clk_div_num, 32'd40);
    wait_edge(c); check_val("post_half", c, 32'd41);
    check_val("post_div2", clk_div_num, 32'd32);
    wait_edge(c); check_val("post_half2", c, 32'd33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
